// File: rtl/croma_update_scheduler.sv
// croma_update_scheduler: debounced button editing of a shadow colour/tone set, committed at vblank start
module croma_update_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19,
  parameter int TON_STEP = 8,
  parameter int TON_RESET = 128,
  parameter int COLORL_RESET = 7,
  parameter int COLORP_RESET = 0
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       TC,
  input  logic       Up,
  input  logic       Down,
  input  logic       Lp,
  input  logic       vblank,
  output logic [2:0] ColorL,
  output logic [2:0] ColorP,
  output logic [7:0] ton,
  output logic       target,
  output logic       pending,
  output logic       commit
);
  typedef enum logic [1:0] {IDLE, PEND, CMT} state_t;
  state_t state, nxt;
  logic [3:0] raw, s1, s2, lvl, lvl_q, ev;
  logic vblank_q, vrise, e_lp, e_tc, e_up, e_dn, ud, acc;
  logic [2:0] sl, sp, sel, oth, inc, nc;
  logic [7:0] st, dn_val, up_val;
  logic [8:0] up_sum;
  assign raw = {Lp, Down, Up, TC};
  always_ff @(posedge Clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      lvl_q <= '0;
      vblank_q <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      lvl_q <= lvl;
      vblank_q <= vblank;
    end
  end
  for (genvar b = 0; b < 4; b++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic l;
    always_ff @(posedge Clock) begin
      if (reset) begin
        cnt <= '0;
        l <= 1'b0;
      end else if (s2[b] != l) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          l <= ~l;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end else cnt <= '0;
    end
    assign lvl[b] = l;
  end
  assign ev = lvl & ~lvl_q;
  // Lp beats TC; tone buttons only count when neither colour button fired, and cancel each other
  assign e_lp = ev[3];
  assign e_tc = ev[0] & ~ev[3];
  assign ud = ~ev[3] & ~ev[0];
  assign e_up = ud & ev[1] & ~ev[2];
  assign e_dn = ud & ev[2] & ~ev[1];
  assign acc = e_lp | e_tc | e_up | e_dn;
  assign vrise = vblank & ~vblank_q;
  assign sel = target ? sl : sp;
  assign oth = target ? sp : sl;
  assign inc = sel + 3'd1;
  assign nc = (inc == oth) ? inc + 3'd1 : inc;
  assign up_sum = {1'b0, st} + 9'(TON_STEP);
  assign up_val = up_sum[8] ? 8'hFF : up_sum[7:0];
  assign dn_val = (st < 8'(TON_STEP)) ? 8'd0 : st - 8'(TON_STEP);
  always_comb begin
    nxt = state == IDLE ? (acc ? PEND : IDLE) :
          state == PEND ? (vrise ? CMT : PEND) :
          (acc ? PEND : IDLE);
  end
  assign commit = state == CMT;
  assign pending = (state == PEND) | (commit & acc);
  always_ff @(posedge Clock) begin
    if (reset) begin
      state <= IDLE;
      target <= 1'b1;
      sl <= 3'(COLORL_RESET);
      sp <= 3'(COLORP_RESET);
      st <= 8'(TON_RESET);
      ColorL <= 3'(COLORL_RESET);
      ColorP <= 3'(COLORP_RESET);
      ton <= 8'(TON_RESET);
    end else begin
      state <= nxt;
      if (e_lp) target <= ~target;
      if (e_tc & target) sl <= nc;
      if (e_tc & ~target) sp <= nc;
      if (e_up) st <= up_val;
      if (e_dn) st <= dn_val;
      if (commit) begin
        ColorL <= sl;
        ColorP <= sp;
        ton <= st;
      end
    end
  end
endmodule

// File: tb/tb_croma_update_scheduler.sv
// tb_croma_update_scheduler: random and directed stimulus checked against a behavioural model
module tb_croma_update_scheduler;
  localparam int D = 4;
  logic Clock = 0, reset = 1, TC = 0, Up = 0, Down = 0, Lp = 0, vblank = 0;
  logic [2:0] ColorL, ColorP;
  logic [7:0] ton;
  logic target, pending, commit;
  int n_cmp = 0, n_bad = 0;
  bit chk = 0;

  croma_update_scheduler #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .Clock(Clock), .reset(reset), .TC(TC), .Up(Up), .Down(Down), .Lp(Lp),
    .vblank(vblank), .ColorL(ColorL), .ColorP(ColorP), .ton(ton),
    .target(target), .pending(pending), .commit(commit));

  always #5 Clock = ~Clock;

  bit [3:0] rh0, rh1, mlvl, rose;
  bit [D-1:0] sh [4];
  bit m_vbp, m_pend, m_com, m_tgt;
  int m_sl, m_sp, m_st, m_l, m_p, m_t;

  function automatic int next_col(int c, int o);
    int n = (c + 1) % 8;
    return (n == o) ? (n + 1) % 8 : n;
  endfunction

  function automatic bit acc_of(bit [3:0] r);
    return r[3] || r[0] || (r[1] != r[2]);
  endfunction

  task automatic step();
    bit [3:0] raw = {Lp, Down, Up, TC};
    bit lp, tc, up, dn, vr, n_com, n_pend;
    if (reset) begin
      rh0 = 0; rh1 = 0; mlvl = 0; rose = 0;
      for (int b = 0; b < 4; b++) sh[b] = 0;
      m_vbp = 0; m_pend = 0; m_com = 0; m_tgt = 1;
      m_sl = 7; m_sp = 0; m_st = 128; m_l = 7; m_p = 0; m_t = 128;
      return;
    end
    lp = rose[3];
    tc = rose[0] && !lp;
    up = !rose[3] && !rose[0] && rose[1] && !rose[2];
    dn = !rose[3] && !rose[0] && rose[2] && !rose[1];
    vr = vblank && !m_vbp;
    if (m_com) begin m_l = m_sl; m_p = m_sp; m_t = m_st; end
    n_com = m_pend && vr;
    n_pend = m_pend ? !vr : (lp || tc || up || dn);
    if (lp) m_tgt = !m_tgt;
    if (tc) begin
      if (m_tgt) m_sl = next_col(m_sl, m_sp);
      else m_sp = next_col(m_sp, m_sl);
    end
    if (up) m_st = (m_st + 8 > 255) ? 255 : m_st + 8;
    if (dn) m_st = (m_st < 8) ? 0 : m_st - 8;
    // a level is accepted once the synchronized input has disagreed with it for D samples in a row
    for (int b = 0; b < 4; b++) begin
      sh[b] = {sh[b][D-2:0], rh1[b]};
      rose[b] = 0;
      if (sh[b] == {D{~mlvl[b]}}) begin
        mlvl[b] = ~mlvl[b];
        rose[b] = mlvl[b];
      end
    end
    rh1 = rh0; rh0 = raw; m_vbp = vblank; m_pend = n_pend; m_com = n_com;
  endtask

  task automatic cmp(string n, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge Clock) if (chk) begin
    cmp("ColorL", ColorL, m_l);
    cmp("ColorP", ColorP, m_p);
    cmp("ton", ton, m_t);
    cmp("target", target, m_tgt);
    cmp("commit", commit, m_com);
    cmp("pending", pending, m_pend || (m_com && acc_of(rose)));
  end

  task automatic tick();
    @(posedge Clock);
    step();
    @(negedge Clock);
  endtask

  task automatic press(bit [3:0] m);
    {Lp, Down, Up, TC} = m;
    repeat (8) tick();
    {Lp, Down, Up, TC} = 0;
    repeat (8) tick();
  endtask

  task automatic vpulse();
    vblank = 1;
    repeat (4) tick();
    vblank = 0;
    repeat (2) tick();
  endtask

  int hold [5];
  initial begin
    repeat (3) tick();
    chk = 1;
    reset = 0;
    tick();
    cmp("rst ColorL", ColorL, 7);
    cmp("rst ColorP", ColorP, 0);
    cmp("rst ton", ton, 128);
    cmp("rst target", target, 1);
    cmp("rst pending", pending, 0);
    TC = 1; repeat (2) tick(); TC = 0; repeat (8) tick();
    cmp("glitch pending", pending, 0);
    TC = 1; repeat (10) tick(); TC = 0;
    cmp("tc pending", pending, 1);
    cmp("tc ColorL held", ColorL, 7);
    repeat (8) tick();
    vpulse();
    cmp("commit ColorL", ColorL, 1);
    cmp("commit pending", pending, 0);
    press(4'b1000);
    press(4'b0001);
    vpulse();
    cmp("bg target", target, 0);
    cmp("bg ColorP", ColorP, 2);
    cmp("bg ColorL", ColorL, 1);
    repeat (16) press(4'b0010);
    cmp("up ton uncommitted", ton, 128);
    vpulse();
    cmp("up ton sat", ton, 255);
    repeat (40) press(4'b0100);
    vpulse();
    cmp("down ton sat", ton, 0);
    press(4'b0110);
    cmp("updown pending", pending, 0);
    cmp("updown ton", ton, 0);
    press(4'b1001);
    vpulse();
    cmp("lp+tc target", target, 1);
    cmp("lp+tc ColorL", ColorL, 1);
    cmp("lp+tc ColorP", ColorP, 2);
    press(4'b0001);
    cmp("pre-reset pending", pending, 1);
    reset = 1; repeat (3) tick(); reset = 0; tick();
    cmp("mid rst pending", pending, 0);
    vpulse();
    cmp("mid rst ColorL", ColorL, 7);
    cmp("mid rst ColorP", ColorP, 0);
    cmp("mid rst ton", ton, 128);
    for (int b = 0; b < 5; b++) hold[b] = $urandom_range(1, 12);
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (--hold[b] == 0) begin
          case (b)
            0: TC = ~TC;
            1: Up = ~Up;
            2: Down = ~Down;
            default: Lp = ~Lp;
          endcase
          hold[b] = $urandom_range(1, 12);
        end
      end
      if (--hold[4] == 0) begin
        vblank = ~vblank;
        hold[4] = $urandom_range(5, 60);
      end
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
